// File: rtl/reg_bus_arb_pkg.sv
// Shared types and defaults for the config-register bus arbiter.
package reg_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_ADDR_W  = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

  // Read data returned on a timeout or a write completion.
  localparam int unsigned ERR_RDATA = 0;

endpackage

// File: rtl/reg_bus_arb_if.sv
// Requester-side and slave-side signals of the shared register bus.
interface reg_bus_arb_if
  import reg_bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = DEF_N_REQ,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [N_REQ-1:0]        m_req;
  logic [N_REQ-1:0]        m_rd_wr;
  logic [N_REQ*ADDR_W-1:0] m_addr;
  logic [N_REQ*DATA_W-1:0] m_wdata;
  logic [N_REQ-1:0]        m_ack;
  logic [N_REQ-1:0]        m_err;
  logic [DATA_W-1:0]       m_rdata;

  logic                    req;
  logic                    rd_wr;
  logic [ADDR_W-1:0]       addr;
  logic [DATA_W-1:0]       write_val;
  logic                    ack;
  logic [DATA_W-1:0]       read_val;

  // Arbiter view.
  modport slave (
    input  m_req, m_rd_wr, m_addr, m_wdata, ack, read_val,
    output m_ack, m_err, m_rdata, req, rd_wr, addr, write_val
  );

  // Environment view: requesters plus the register slave.
  modport master (
    output m_req, m_rd_wr, m_addr, m_wdata, ack, read_val,
    input  m_ack, m_err, m_rdata, req, rd_wr, addr, write_val
  );

endinterface

// File: rtl/reg_bus_arb_rr_pick.sv
// Combinational round-robin select: first set request at or after i_ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  localparam int unsigned SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] w_pos;

  // Scan from the farthest offset down so the nearest request to i_ptr wins.
  always_comb begin
    o_gnt_c = '0;
    o_idx_c = '0;
    w_pos   = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      w_pos = SUM_W'(i_ptr) + SUM_W'(off);
      if (w_pos >= SUM_W'(N_REQ)) begin
        w_pos = w_pos - SUM_W'(N_REQ);
      end
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_gnt_c                    = '0;
        o_gnt_c[w_pos[IDX_W-1:0]]  = 1'b1;
        o_idx_c                    = w_pos[IDX_W-1:0];
      end
    end
  end

  assign o_valid_c = |i_req;

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter serialising N_REQ requesters onto one register bus,
// with forced error completion when the slave never acknowledges.
module reg_bus_arb
  import reg_bus_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_L,
  reg_bus_arb_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_t              r_state,  w_state_nxt;
  logic [IDX_W-1:0]    r_ptr,    w_ptr_nxt;
  logic [IDX_W-1:0]    r_gnt_id, w_gnt_nxt;
  logic                r_req,    w_req_nxt;
  logic                r_rd_wr,  w_rd_wr_nxt;
  logic [ADDR_W-1:0]   r_addr,   w_addr_nxt;
  logic [DATA_W-1:0]   r_wval,   w_wval_nxt;
  logic [DATA_W-1:0]   r_rdata,  w_rdata_nxt;
  logic [N_REQ-1:0]    r_m_ack,  w_m_ack_nxt;
  logic [N_REQ-1:0]    r_m_err,  w_m_err_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
  logic                r_to,     w_to_nxt;

  logic [N_REQ-1:0]    w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_valid;
  logic                w_win_rd_wr;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wval;
  logic                w_finish;
  logic                w_fin_err;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req     (bus.m_req),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_pick_gnt),
    .o_idx_c   (w_pick_idx),
    .o_valid_c (w_pick_valid)
  );

  // Winner's command fields, selected by the one-hot grant.
  always_comb begin
    w_win_rd_wr = |(w_pick_gnt & bus.m_rd_wr);
    w_win_addr  = '0;
    w_win_wval  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_win_addr = bus.m_addr[i*ADDR_W +: ADDR_W];
        w_win_wval = bus.m_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt_id;
    w_req_nxt   = 1'b0;
    w_rd_wr_nxt = r_rd_wr;
    w_addr_nxt  = r_addr;
    w_wval_nxt  = r_wval;
    w_rdata_nxt = '0;
    w_m_ack_nxt = '0;
    w_m_err_nxt = '0;
    w_cnt_nxt   = r_cnt;
    w_to_nxt    = r_to;
    w_finish    = 1'b0;
    w_fin_err   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_rd_wr_nxt = 1'b0;
        w_addr_nxt  = '0;
        w_wval_nxt  = '0;
        if (w_pick_valid) begin
          w_state_nxt = ST_ISSUE;
          w_gnt_nxt   = w_pick_idx;
          w_req_nxt   = 1'b1;
          w_rd_wr_nxt = w_win_rd_wr;
          w_addr_nxt  = w_win_addr;
          w_wval_nxt  = w_win_wval;
        end
      end

      ST_ISSUE: begin
        w_cnt_nxt = '0;
        w_to_nxt  = 1'b0;
        if (bus.ack) begin
          w_finish = 1'b1;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end

      // Once the counter has expired, an ack in the final cycle is treated as late.
      ST_WAIT: begin
        if (r_to) begin
          w_finish  = 1'b1;
          w_fin_err = 1'b1;
        end else if (bus.ack) begin
          w_finish = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            w_to_nxt = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = (r_gnt_id == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_id + IDX_W'(1);
        w_rd_wr_nxt = 1'b0;
        w_addr_nxt  = '0;
        w_wval_nxt  = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_finish) begin
      w_state_nxt           = ST_DONE;
      w_m_ack_nxt[r_gnt_id] = 1'b1;
      w_m_err_nxt[r_gnt_id] = w_fin_err;
      w_rdata_nxt           = (!w_fin_err && r_rd_wr) ? bus.read_val : DATA_W'(ERR_RDATA);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gnt_id <= '0;
      r_req    <= 1'b0;
      r_rd_wr  <= 1'b0;
      r_addr   <= '0;
      r_wval   <= '0;
      r_rdata  <= '0;
      r_m_ack  <= '0;
      r_m_err  <= '0;
      r_cnt    <= '0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_gnt_id <= w_gnt_nxt;
      r_req    <= w_req_nxt;
      r_rd_wr  <= w_rd_wr_nxt;
      r_addr   <= w_addr_nxt;
      r_wval   <= w_wval_nxt;
      r_rdata  <= w_rdata_nxt;
      r_m_ack  <= w_m_ack_nxt;
      r_m_err  <= w_m_err_nxt;
      r_cnt    <= w_cnt_nxt;
      r_to     <= w_to_nxt;
    end
  end

  assign bus.m_ack     = r_m_ack;
  assign bus.m_err     = r_m_err;
  assign bus.m_rdata   = r_rdata;
  assign bus.req       = r_req;
  assign bus.rd_wr     = r_rd_wr;
  assign bus.addr      = r_addr;
  assign bus.write_val = r_wval;

endmodule

// File: tb/tb_reg_bus_arb.sv
// Bench for reg_bus_arb: transaction-timeline model checked every cycle plus directed literal checks.
module tb_reg_bus_arb;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_L;

  reg_bus_arb_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  reg_bus_arb #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Slave behaviour controlled by the stimulus.
  bit                slave_on   = 1'b1;
  logic [DATA_W-1:0] slave_data = '0;

  // Observation log, filled while comparing.
  int                last_req_cyc = 0;
  int                last_ack_cyc = 0;
  int                req_pulses   = 0;
  int                n_acks       = 0;
  logic [N_REQ-1:0]  last_ack     = '0;
  logic [N_REQ-1:0]  last_err     = '0;
  logic [DATA_W-1:0] last_rdata   = '0;
  logic [ADDR_W-1:0] last_addr    = '0;
  logic [DATA_W-1:0] last_wval    = '0;
  logic              last_rdwr    = 1'b0;
  int                order_q[$];

  // Transaction-timeline model: a transaction starts at the edge where an idle
  // arbiter sees requests; req is high the cycle after; completion lands the
  // cycle after an accepted ack, or TIMEOUT+2 cycles after req.
  int                m_cyc    = 0;
  bit                m_busy   = 1'b0;
  int                m_ptr    = 0;
  int                m_win    = 0;
  int                m_tstart = 0;
  int                m_tdone  = -1;
  bit                m_err    = 1'b0;
  bit                m_rd     = 1'b0;
  logic [ADDR_W-1:0] m_addr   = '0;
  logic [DATA_W-1:0] m_wdat   = '0;
  logic [DATA_W-1:0] m_rdat   = '0;

  function automatic int pick(input logic [N_REQ-1:0] r, input int p);
    for (int off = 0; off < N_REQ; off++) begin
      if (r[(p + off) % N_REQ]) return (p + off) % N_REQ;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge reset_L) begin : mdl
    int n;
    int w;
    if (!reset_L) begin
      m_busy  <= 1'b0;
      m_ptr   <= 0;
      m_tdone <= -1;
    end else begin
      n = m_cyc + 1;
      m_cyc <= n;
      if (m_busy) begin
        if (m_tdone < 0) begin
          if (bus.ack && (n - 1) <= m_tstart + TIMEOUT) begin
            m_tdone <= n;
            m_err   <= 1'b0;
            m_rdat  <= m_rd ? bus.read_val : '0;
          end else if (n == m_tstart + TIMEOUT + 2) begin
            m_tdone <= n;
            m_err   <= 1'b1;
            m_rdat  <= '0;
          end
        end else if (n == m_tdone + 1) begin
          m_busy <= 1'b0;
          m_ptr  <= (m_win + 1) % N_REQ;
        end
      end else if (bus.m_req != '0) begin
        w = pick(bus.m_req, m_ptr);
        m_busy   <= 1'b1;
        m_win    <= w;
        m_tstart <= n;
        m_tdone  <= -1;
        m_rd     <= bus.m_rd_wr[w];
        m_addr   <= bus.m_addr[w*ADDR_W +: ADDR_W];
        m_wdat   <= bus.m_wdata[w*DATA_W +: DATA_W];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit                active;
    bit                done;
    logic [N_REQ-1:0]  e_ack;
    logic [N_REQ-1:0]  e_err;
    active = m_busy;
    done   = m_busy && (m_tdone == m_cyc);
    e_ack  = '0;
    e_err  = '0;
    if (done) begin
      e_ack[m_win] = 1'b1;
      e_err[m_win] = m_err;
    end
    check("req",       64'(bus.req),       64'(active && m_cyc == m_tstart));
    check("rd_wr",     64'(bus.rd_wr),     64'(active ? m_rd : 1'b0));
    check("addr",      64'(bus.addr),      64'(active ? m_addr : '0));
    check("write_val", 64'(bus.write_val), 64'(active ? m_wdat : '0));
    check("m_ack",     64'(bus.m_ack),     64'(e_ack));
    check("m_err",     64'(bus.m_err),     64'(e_err));
    check("m_rdata",   64'(bus.m_rdata),   64'(done ? m_rdat : '0));

    if (bus.req) begin
      last_req_cyc = m_cyc;
      req_pulses++;
    end
    if (bus.m_ack != '0) begin
      n_acks++;
      last_ack_cyc = m_cyc;
      last_ack     = bus.m_ack;
      last_err     = bus.m_err;
      last_rdata   = bus.m_rdata;
      last_addr    = bus.addr;
      last_wval    = bus.write_val;
      last_rdwr    = bus.rd_wr;
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.m_ack[i]) order_q.push_back(i);
      end
    end
  endtask

  // One clock: compare at the falling edge, then drive requesters and slave just after the rising edge.
  task automatic tick(input bit spur = 1'b0);
    logic [N_REQ-1:0] seen_ack;
    logic             seen_req;
    @(negedge clk);
    compare_cycle();
    seen_ack = bus.m_ack;
    seen_req = bus.req;
    @(posedge clk);
    #1;
    bus.m_req    = bus.m_req & ~seen_ack;
    bus.ack      = 1'b0;
    bus.read_val = '0;
    if ((seen_req && slave_on) || spur) begin
      bus.ack      = 1'b1;
      bus.read_val = slave_data;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (bus.m_req != '0 && k < max_cyc) begin
      tick();
      k++;
    end
    if (bus.m_req != '0) begin
      n_vec++;
      n_mis++;
      $display("FAIL wait_idle: requests %0h still pending after %0d cycles", bus.m_req, max_cyc);
    end
    run(2);
  endtask

  task automatic set_req(input int i, input bit rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    bus.m_rd_wr[i]                   = rd;
    bus.m_addr[i*ADDR_W +: ADDR_W]   = a;
    bus.m_wdata[i*DATA_W +: DATA_W]  = d;
    bus.m_req[i]                     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int a0;
    int p0;
    reset_L      = 1'b0;
    bus.m_req    = '0;
    bus.m_rd_wr  = '0;
    bus.m_addr   = '0;
    bus.m_wdata  = '0;
    bus.ack      = 1'b0;
    bus.read_val = '0;
    run(3);
    check("rst_m_ack",   64'(bus.m_ack),     64'(0));
    check("rst_req",     64'(bus.req),       64'(0));
    check("rst_m_rdata", 64'(bus.m_rdata),   64'(0));
    reset_L = 1'b1;
    run(2);

    // Single read by requester 2.
    slave_on   = 1'b1;
    slave_data = 32'h0000_00A5;
    p0 = req_pulses;
    set_req(2, 1'b1, 4'h3, 32'h0);
    wait_idle(20);
    check("rd_ack",     64'(last_ack),                   64'(4'b0100));
    check("rd_rdata",   64'(last_rdata),                 64'(32'h0000_00A5));
    check("rd_err",     64'(last_err),                   64'(0));
    check("rd_latency", 64'(last_ack_cyc - last_req_cyc), 64'(2));
    check("rd_pulses",  64'(req_pulses - p0),            64'(1));

    // Write by requester 0.
    slave_data = 32'h1234_5678;
    set_req(0, 1'b0, 4'h1, 32'hFFFF_FFFF);
    wait_idle(20);
    check("wr_ack",   64'(last_ack),   64'(4'b0001));
    check("wr_rdata", 64'(last_rdata), 64'(0));
    check("wr_addr",  64'(last_addr),  64'(1));
    check("wr_wval",  64'(last_wval),  64'(32'hFFFF_FFFF));
    check("wr_rdwr",  64'(last_rdwr),  64'(0));

    // Contention straight after reset, then again after requester 1 alone.
    reset_L = 1'b0;
    run(1);
    reset_L = 1'b1;
    slave_data = 32'hCAFE_0000;
    b = order_q.size();
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 4'(i), 32'h0);
    wait_idle(40);
    set_req(1, 1'b1, 4'h7, 32'h0);
    wait_idle(20);
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 4'(8 + i), 32'h0);
    wait_idle(40);
    check("ord_a0", 64'(order_q[b+0]), 64'(0));
    check("ord_a1", 64'(order_q[b+1]), 64'(1));
    check("ord_a2", 64'(order_q[b+2]), 64'(2));
    check("ord_a3", 64'(order_q[b+3]), 64'(3));
    check("ord_s",  64'(order_q[b+4]), 64'(1));
    check("ord_b0", 64'(order_q[b+5]), 64'(2));
    check("ord_b1", 64'(order_q[b+6]), 64'(3));
    check("ord_b2", 64'(order_q[b+7]), 64'(0));
    check("ord_b3", 64'(order_q[b+8]), 64'(1));

    // Timeout with a late ack landing in the completion cycle.
    slave_on = 1'b0;
    set_req(1, 1'b1, 4'h2, 32'h0);
    run(TIMEOUT + 2);
    tick(1'b1);
    wait_idle(10);
    check("to_ack",     64'(last_ack),                   64'(4'b0010));
    check("to_err",     64'(last_err),                   64'(4'b0010));
    check("to_rdata",   64'(last_rdata),                 64'(0));
    check("to_latency", 64'(last_ack_cyc - last_req_cyc), 64'(TIMEOUT + 2));
    slave_on   = 1'b1;
    slave_data = 32'h0BAD_F00D;
    set_req(3, 1'b1, 4'h4, 32'h0);
    wait_idle(20);
    check("post_to_ack",     64'(last_ack),                   64'(4'b1000));
    check("post_to_err",     64'(last_err),                   64'(0));
    check("post_to_rdata",   64'(last_rdata),                 64'(32'h0BAD_F00D));
    check("post_to_latency", 64'(last_ack_cyc - last_req_cyc), 64'(2));

    // Spurious ack while idle, then reset while waiting on the slave.
    a0 = n_acks;
    tick(1'b1);
    run(2);
    check("spur_noack", 64'(n_acks), 64'(a0));
    slave_on = 1'b0;
    set_req(0, 1'b1, 4'h5, 32'h0);
    run(5);
    reset_L   = 1'b0;
    bus.m_req = '0;
    run(2);
    check("mid_rst_m_ack", 64'(bus.m_ack), 64'(0));
    check("mid_rst_addr",  64'(bus.addr),  64'(0));
    check("mid_rst_acks",  64'(n_acks),    64'(a0));
    reset_L    = 1'b1;
    slave_on   = 1'b1;
    slave_data = 32'h0000_005A;
    set_req(3, 1'b1, 4'h6, 32'h0);
    wait_idle(20);
    check("rst_next_ack",     64'(last_ack),                   64'(4'b1000));
    check("rst_next_rdata",   64'(last_rdata),                 64'(32'h0000_005A));
    check("rst_next_latency", 64'(last_ack_cyc - last_req_cyc), 64'(2));
    check("rst_next_count",   64'(n_acks - a0),                64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/reg_bus_arb.md
# reg_bus_arb

Round-robin arbiter sharing the single config-register bus (req/rd_wr/addr/write_val in, ack/read_val out) of `regs` between N_REQ independent requesters. Serialises one transaction at a time, holds address/data stable for the slave, routes ack and read data back to the winner, and completes hung transactions with an error after a timeout. Sits between requesters (CPU bridge, debug port, init sequencer) and `regs`.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 4, register address width
- DATA_W, 32, data width
- TIMEOUT, 16, cycles waited for slave `ack` before forced error completion (>=2)
- clk  in  1  clock, all logic on rising edge
- reset_L  in  1  asynchronous active-low reset
- m_req  in  N_REQ  per-requester request level; held high until that requester's `m_ack`
- m_rd_wr  in  N_REQ  per-requester 1=read, 0=write; stable while `m_req` high
- m_addr  in  N_REQ*ADDR_W  per-requester address, requester i at bits [i*ADDR_W +: ADDR_W]
- m_wdata  in  N_REQ*DATA_W  per-requester write data, same packing
- m_ack  out  N_REQ  one-cycle completion pulse to the granted requester
- m_err  out  N_REQ  asserted with `m_ack` when completion was a timeout
- m_rdata  out  DATA_W  read data, valid only in the `m_ack` cycle
- req  out  1  one-cycle request pulse to slave
- rd_wr  out  1  to slave, 1=read
- addr  out  ADDR_W  to slave
- write_val  out  DATA_W  to slave
- ack  in  1  slave completion pulse; `read_val` valid in same cycle
- read_val  in  DATA_W  slave read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any `m_req` bit set, pick winner round-robin starting at `ptr`; register `gnt_id`, `rd_wr`, `addr`, `write_val` from winner; go ISSUE. Else stay.
- ISSUE: `req`=1 for exactly this cycle; clear timeout counter; go WAIT. `ack` in this cycle is accepted as in WAIT.
- WAIT: on `ack`, capture `read_val` (reads) or zero (writes) into `m_rdata`, go DONE. Counter increments each WAIT cycle; at count == TIMEOUT-1 without `ack`, set error flag, `m_rdata`=0, go DONE.
- DONE: `m_ack[gnt_id]`=1, `m_err[gnt_id]`=error flag; `ptr` <= gnt_id+1 mod N_REQ; go IDLE.
- `addr`, `rd_wr`, `write_val` hold stable from ISSUE through DONE; return to 0 in IDLE.
- `ack` outside ISSUE/WAIT ignored (no effect on state, data, or counter).
- Late `ack` for a timed-out transaction arriving in DONE/IDLE is ignored.
- Requester drops `m_req` the cycle after `m_ack`; arbiter never samples `m_req` in DONE, so no double grant.
- Reset (any time, including mid-transaction): state IDLE, `ptr`=0, all outputs 0; in-flight transaction abandoned with no `m_ack`.

## Timing
- Reset values: `m_ack`, `m_err`, `m_rdata`, `req`, `rd_wr`, `addr`, `write_val` all 0.
- All outputs registered; no combinational path input→output.
- `m_req` first sampled in IDLE at edge k → `req` high in cycle k+1 → `m_ack` earliest cycle k+3 (slave `ack` in k+2).
- Minimum throughput: one transaction per 4 cycles (IDLE, ISSUE, WAIT, DONE).
- Timeout: `m_ack`/`m_err` exactly TIMEOUT+2 cycles after `req`.
- Simultaneous requests: grant order strictly rotates from `ptr`; after all N_REQ requesters hold `m_req`, grants are ptr, ptr+1, ... with wrap from N_REQ-1 to 0.

## Structure
- Package `reg_bus_arb_pkg`: FSM state enum (2-bit), default TIMEOUT, error-read constant (0).
- Sub-module `rr_pick`: combinational round-robin select given request vector and `ptr`; outputs one-hot grant and index, plus valid. Pointer register stays in parent.
- Timeout counter width $clog2(TIMEOUT).

## Test plan
- Single read: requester 2 reads addr 0x3, slave `ack` 1 cycle after `req` with 0x0000_00A5 -> `req` one pulse, `m_ack[2]`=1, `m_rdata`=0x0000_00A5, `m_err`=0, at cycle k+3.
- Write: requester 0 writes 0xFFFF_FFFF to addr 0x1 -> slave sees `rd_wr`=0, `addr`=1, `write_val`=0xFFFF_FFFF held until DONE; `m_rdata`=0.
- Contention: all 4 request reads in same cycle after reset -> grant order 0,1,2,3; next all-request round after requester 1 alone goes 2,3,0,1.
- Timeout: slave never acks, TIMEOUT=16 -> `m_ack`+`m_err` for winner 18 cycles after `req`, `m_rdata`=0; late `ack` afterwards ignored, next transaction unaffected.
- Spurious `ack` in IDLE and reset asserted in WAIT -> no `m_ack` produced, all outputs 0, `ptr`=0, next request from requester 3 served normally.
